tl_channel_monitor: RTL and testbench
=====================================

// Module: tl_channel_monitor
// PURPOSE
//  Parametrised, synthesizable protocol monitor for NUM_CH valid/ready channels (TileLink A-E) in the L2/L3 testbench.
//  Per channel it flags valid drops and payload changes before handshake, plus stalls longer than TIMEOUT cycles.
//  Violations are reported as registered error pulses and a sticky first-error record, with per-channel fire counters.
//  Instantiated beside tb_top.l_soc; it replaces hand-written inline assertions with a reusable checker.
// PARAMETERS
//  NUM_CH    4    number of monitored channels (1..16)
//  DATA_W    64   payload width per channel, compared bit-exact
//  TIMEOUT   1000 max consecutive valid&&!ready cycles before STALL_TIMEOUT (>=2)
//  CNT_W     32   width of the fire and error counters
// PORTS
//  clock       in   1              sole clock; all logic on posedge
//  reset       in   1              synchronous, active-high
//  enable      in   1              1 = checking active
//  clear       in   1              1-cycle pulse: clears sticky record and err_count
//  ch_valid    in   NUM_CH         per-channel valid
//  ch_ready    in   NUM_CH         per-channel ready
//  ch_payload  in   NUM_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
//  err_valid   out  1              1-cycle pulse: a violation was detected in the previous cycle
//  err_code    out  2              1 VALID_DROP, 2 PAYLOAD_CHANGE, 3 STALL_TIMEOUT, 0 none
//  err_ch      out  max(1,$clog2(NUM_CH))  channel reported on err_valid
//  sticky_err  out  1              first error seen since reset/clear
//  sticky_code out  2              code of the first error
//  sticky_ch   out  max(1,$clog2(NUM_CH))  channel of the first error
//  err_count   out  CNT_W          total violations, saturating
//  fire_cnt    out  NUM_CH*CNT_W   per-channel handshakes (valid&&ready), saturating
// BEHAVIOUR
//  Reset: all outputs 0, every channel FSM in IDLE, stall counters 0.
//  Per-channel FSM, evaluated each cycle while enable=1:
//   IDLE: valid&&!ready -> WAIT, latch payload, stall=1; else stay IDLE.
//   WAIT:
//    - !valid -> VALID_DROP, go to IDLE.
//    - valid && payload!=latched -> PAYLOAD_CHANGE; relatch payload, stay WAIT.
//    - valid&&ready with matching payload -> IDLE (handshake).
//    - valid&&!ready -> stall++ (saturate at TIMEOUT).
//   STALL_TIMEOUT fires once per stall episode, in the cycle stall reaches TIMEOUT;
//    re-arms only after the FSM returns to IDLE.
//  Per-channel priority in one cycle: VALID_DROP > PAYLOAD_CHANGE > STALL_TIMEOUT (one code per channel).
//   A PAYLOAD_CHANGE cycle with ready=1 also completes the handshake (FSM -> IDLE).
//  Cross-channel: when several channels err in the same cycle, err_ch/err_code report the lowest index.
//   err_count increments by the number of erring channels that cycle, saturating at all-ones.
//  Latency: a violation in cycle t gives err_valid=1 in cycle t+1 with code and channel;
//   err_code/err_ch are 0 when err_valid=0.
//  Sticky record: loads on the first err_valid after reset/clear and holds until reset/clear.
//   clear in the same cycle as a new detection: clear wins and that detection is also dropped from err_count.
//  fire_cnt[i] increments on every valid&&ready while enable=1, including in IDLE; it saturates at all-ones.
//  enable=0: no detection; FSMs forced to IDLE, stall counters zeroed, all counters and sticky hold.
//   Checking restarts cleanly when enable returns to 1.
//  Reset mid-stall or mid-WAIT: FSMs return to IDLE with no error pulse; counters clear.
//  No combinational path from inputs to outputs.
// TESTING
//  1 ch0 valid=1 ready=0 for 3 cycles then ready=1, payload constant 0xA5
//    -> no err_valid; fire_cnt[0]=1.
//  2 ch1 valid=1 ready=0 at cycle 10, valid=0 at cycle 11
//    -> err_valid=1 at cycle 12, err_code=1, err_ch=1; sticky_code=1; err_count=1.
//  3 ch2 waiting with payload 0x10, changes to 0x11 at cycle 20
//    -> err_valid at 21, code=2, ch=2; then ready=1 at 22 -> handshake, fire_cnt[2]=1.
//  4 TIMEOUT=8: ch3 valid=1 ready=0 for 20 cycles
//    -> exactly one err_valid (code 3) in the cycle after stall=8; no repeat; err_count=1.
//  5 ch0 VALID_DROP and ch3 PAYLOAD_CHANGE in the same cycle
//    -> err_ch=0, err_code=1, err_count +2; sticky keeps the earlier record if already set.
//  6 clear asserted with a pending detection
//    -> sticky_err=0 and err_count=0 next cycle; with enable=0, a valid drop is never reported.

Source files
------------

// File: rtl/tl_channel_monitor.sv
// Purpose : valid/ready protocol checker for NUM_CH channels; flags valid drops, payload
//           changes before handshake and over-long stalls, with sticky record and counters.
// Latency : a violation seen in cycle t is reported on err_valid_o in cycle t+1; passive, applies no backpressure.
// Ports   : clock_i/reset_i (sync, active-high), enable_i, clear_i, ch_valid_i/ch_ready_i/ch_payload_i
//           (channel i at [i*DATA_W +: DATA_W]); err_valid_o/err_code_o/err_ch_o pulse report,
//           sticky_err_o/sticky_code_o/sticky_ch_o first-error record, err_count_o, fire_cnt_o (channel i at [i*CNT_W +: CNT_W]).
module tl_channel_monitor #(
    parameter int NUM_CH  = 4,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1000,
    parameter int CNT_W   = 32,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock_i,
    input  logic                      reset_i,
    input  logic                      enable_i,
    input  logic                      clear_i,
    input  logic [NUM_CH-1:0]         ch_valid_i,
    input  logic [NUM_CH-1:0]         ch_ready_i,
    input  logic [NUM_CH*DATA_W-1:0]  ch_payload_i,
    output logic                      err_valid_o,
    output logic [1:0]                err_code_o,
    output logic [CH_W-1:0]           err_ch_o,
    output logic                      sticky_err_o,
    output logic [1:0]                sticky_code_o,
    output logic [CH_W-1:0]           sticky_ch_o,
    output logic [CNT_W-1:0]          err_count_o,
    output logic [NUM_CH*CNT_W-1:0]   fire_cnt_o
);

    localparam int ST_W   = $clog2(TIMEOUT + 1);
    localparam int NSUM_W = $clog2(NUM_CH + 1);
    localparam logic [ST_W-1:0] TO_V  = ST_W'(TIMEOUT);
    localparam logic [ST_W-1:0] TO_M1 = ST_W'(TIMEOUT - 1);

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_DROP = 2'd1;
    localparam logic [1:0] C_CHG  = 2'd2;
    localparam logic [1:0] C_STALL = 2'd3;

    typedef enum logic {IDLE, WAIT} state_e;

    state_e                           state_q [NUM_CH];
    state_e                           state_d [NUM_CH];
    logic [NUM_CH-1:0][ST_W-1:0]      stall_q, stall_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    latch_q, latch_d;
    logic [NUM_CH-1:0][DATA_W-1:0]    pay;
    logic [NUM_CH-1:0][CNT_W-1:0]     fire_q, fire_d;
    logic [NUM_CH-1:0][1:0]           code;

    logic                 det_any;
    logic [1:0]           det_code;
    logic [CH_W-1:0]      det_ch;
    logic [NSUM_W-1:0]    det_n;
    logic [CNT_W:0]       cnt_sum;

    logic                 err_valid_q;
    logic [1:0]           err_code_q;
    logic [CH_W-1:0]      err_ch_q;
    logic                 sticky_err_q, sticky_err_d;
    logic [1:0]           sticky_code_q, sticky_code_d;
    logic [CH_W-1:0]      sticky_ch_q, sticky_ch_d;
    logic [CNT_W-1:0]     err_count_q, err_count_d;

    assign pay = ch_payload_i;

    // Per-channel FSM: one code per channel per cycle, priority drop > change > stall.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            stall_d[i] = stall_q[i];
            latch_d[i] = latch_q[i];
            code[i]    = C_NONE;
            fire_d[i]  = fire_q[i];
            if (enable_i && ch_valid_i[i] && ch_ready_i[i] && (fire_q[i] != '1)) begin
                fire_d[i] = fire_q[i] + 1'b1;
            end
            if (!enable_i) begin
                state_d[i] = IDLE;
                stall_d[i] = '0;
            end else begin
                case (state_q[i])
                    IDLE: begin
                        if (ch_valid_i[i] && !ch_ready_i[i]) begin
                            state_d[i] = WAIT;
                            latch_d[i] = pay[i];
                            stall_d[i] = ST_W'(1);
                        end
                    end
                    WAIT: begin
                        if (!ch_valid_i[i]) begin
                            code[i]    = C_DROP;
                            state_d[i] = IDLE;
                            stall_d[i] = '0;
                        end else begin
                            if (pay[i] != latch_q[i]) begin
                                code[i]    = C_CHG;
                                latch_d[i] = pay[i];
                            end
                            if (ch_ready_i[i]) begin
                                state_d[i] = IDLE;
                                stall_d[i] = '0;
                            end else if (stall_q[i] != TO_V) begin
                                stall_d[i] = stall_q[i] + 1'b1;
                                // Saturation at TIMEOUT makes this edge occur once per episode.
                                if ((stall_q[i] == TO_M1) && (code[i] == C_NONE)) begin
                                    code[i] = C_STALL;
                                end
                            end
                        end
                    end
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    // Walk from the top so the lowest erring index is the one left reported.
    always_comb begin
        det_any  = 1'b0;
        det_code = C_NONE;
        det_ch   = '0;
        det_n    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (code[i] != C_NONE) begin
                det_any  = 1'b1;
                det_code = code[i];
                det_ch   = CH_W'(i);
                det_n    = det_n + 1'b1;
            end
        end
    end

    assign cnt_sum = {1'b0, err_count_q} + (CNT_W + 1)'(det_n);

    // clear beats a same-cycle detection for both the record and the count.
    always_comb begin
        err_count_d   = err_count_q;
        sticky_err_d  = sticky_err_q;
        sticky_code_d = sticky_code_q;
        sticky_ch_d   = sticky_ch_q;
        if (clear_i) begin
            err_count_d   = '0;
            sticky_err_d  = 1'b0;
            sticky_code_d = C_NONE;
            sticky_ch_d   = '0;
        end else begin
            err_count_d = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
            if (!sticky_err_q && det_any) begin
                sticky_err_d  = 1'b1;
                sticky_code_d = det_code;
                sticky_ch_d   = det_ch;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= IDLE;
            end
            stall_q       <= '0;
            latch_q       <= '0;
            fire_q        <= '0;
            err_valid_q   <= 1'b0;
            err_code_q    <= C_NONE;
            err_ch_q      <= '0;
            sticky_err_q  <= 1'b0;
            sticky_code_q <= C_NONE;
            sticky_ch_q   <= '0;
            err_count_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            stall_q       <= stall_d;
            latch_q       <= latch_d;
            fire_q        <= fire_d;
            err_valid_q   <= det_any;
            err_code_q    <= det_code;
            err_ch_q      <= det_ch;
            sticky_err_q  <= sticky_err_d;
            sticky_code_q <= sticky_code_d;
            sticky_ch_q   <= sticky_ch_d;
            err_count_q   <= err_count_d;
        end
    end

    assign err_valid_o   = err_valid_q;
    assign err_code_o    = err_code_q;
    assign err_ch_o      = err_ch_q;
    assign sticky_err_o  = sticky_err_q;
    assign sticky_code_o = sticky_code_q;
    assign sticky_ch_o   = sticky_ch_q;
    assign err_count_o   = err_count_q;
    assign fire_cnt_o    = fire_q;

endmodule

// File: tb/tb_tl_channel_monitor.sv
// Purpose : directed bench for tl_channel_monitor with a cycle model and literal spot checks.
// Latency : model predicts registered outputs one edge after the inputs it sees.
// Ports   : none (top-level bench).
module tb_tl_channel_monitor;
    localparam int NCH = 4;
    localparam int DW  = 16;
    localparam int TO  = 8;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, enable, clear;
    logic [NCH-1:0]    vld, rdy;
    logic [DW-1:0]     pay [NCH];
    logic [NCH*DW-1:0] pay_flat;
    logic              err_valid, sticky_err;
    logic [1:0]        err_code, sticky_code;
    logic [1:0]        err_ch, sticky_ch;
    logic [CW-1:0]     err_count;
    logic [NCH*CW-1:0] fire_cnt;

    assign pay_flat = {pay[3], pay[2], pay[1], pay[0]};

    tl_channel_monitor #(.NUM_CH(NCH), .DATA_W(DW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clock_i(clk), .reset_i(reset), .enable_i(enable), .clear_i(clear),
        .ch_valid_i(vld), .ch_ready_i(rdy), .ch_payload_i(pay_flat),
        .err_valid_o(err_valid), .err_code_o(err_code), .err_ch_o(err_ch),
        .sticky_err_o(sticky_err), .sticky_code_o(sticky_code), .sticky_ch_o(sticky_ch),
        .err_count_o(err_count), .fire_cnt_o(fire_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] fire_of(input int ch);
        logic [CW-1:0] v;
        v = fire_cnt[ch*CW +: CW];
        return {28'd0, v};
    endfunction

    // ---------------- behavioural model ----------------
    int         m_wait [NCH];   // 0 = not waiting, else consecutive stalled cycles
    logic [DW-1:0] m_lat [NCH];
    int         m_fire [NCH];
    int         m_cnt, m_scode, m_sch, e_code, e_ch, nerr, first;
    int         codes [NCH];
    logic       m_stk, e_vld, chg;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_wait[i] = 0; m_lat[i] = '0; m_fire[i] = 0;
            end
            m_cnt = 0; m_stk = 1'b0; m_scode = 0; m_sch = 0;
            e_vld = 1'b0; e_code = 0; e_ch = 0;
        end else begin
            nerr = 0; first = -1;
            for (int i = 0; i < NCH; i++) begin
                codes[i] = 0;
                if (!enable) begin
                    m_wait[i] = 0;
                end else begin
                    if (vld[i] && rdy[i] && m_fire[i] < SAT) m_fire[i]++;
                    if (m_wait[i] == 0) begin
                        if (vld[i] && !rdy[i]) begin
                            m_wait[i] = 1; m_lat[i] = pay[i];
                        end
                    end else if (!vld[i]) begin
                        codes[i] = 1; m_wait[i] = 0;
                    end else begin
                        chg = (pay[i] != m_lat[i]);
                        if (chg) begin codes[i] = 2; m_lat[i] = pay[i]; end
                        if (rdy[i]) m_wait[i] = 0;
                        else if (m_wait[i] < TO) begin
                            m_wait[i]++;
                            if (m_wait[i] == TO && !chg) codes[i] = 3;
                        end
                    end
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (codes[i] != 0) begin
                    nerr++;
                    if (first < 0) first = i;
                end
            end
            e_vld  = (nerr > 0);
            e_code = (first >= 0) ? codes[first] : 0;
            e_ch   = (first >= 0) ? first : 0;
            if (clear) begin
                m_cnt = 0; m_stk = 1'b0; m_scode = 0; m_sch = 0;
            end else begin
                m_cnt = (m_cnt + nerr > SAT) ? SAT : m_cnt + nerr;
                if (!m_stk && nerr > 0) begin
                    m_stk = 1'b1; m_scode = e_code; m_sch = e_ch;
                end
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_err_valid", err_valid, e_vld);
            chk("m_err_code", err_code, e_code);
            chk("m_err_ch", err_ch, e_ch);
            chk("m_sticky_err", sticky_err, m_stk);
            chk("m_sticky_code", sticky_code, m_scode);
            chk("m_sticky_ch", sticky_ch, m_sch);
            chk("m_err_count", err_count, m_cnt);
            for (int i = 0; i < NCH; i++) chk($sformatf("m_fire_cnt%0d", i), fire_of(i), m_fire[i]);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int pulses, pk, pcode;

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; vld = '0; rdy = '0;
        for (int i = 0; i < NCH; i++) pay[i] = '0;
        cyc(2);
        cmp_en = 1'b1;
        cyc(1);
        chk("rst_err_valid", err_valid, 0);
        chk("rst_sticky", sticky_err, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_fire", fire_cnt, 0);
        reset = 1'b0; enable = 1'b1;
        cyc(1);

        // 1: stall then handshake, payload constant
        vld[0] = 1'b1; pay[0] = 16'h00A5;
        cyc(3);
        rdy[0] = 1'b1;
        cyc(1);
        chk("t1_fire0", fire_of(0), 1);
        chk("t1_err_valid", err_valid, 0);
        vld[0] = 1'b0; rdy[0] = 1'b0;
        cyc(1);

        // 2: valid drop on ch1
        vld[1] = 1'b1; pay[1] = 16'h0001;
        cyc(1);
        vld[1] = 1'b0;
        cyc(1);
        chk("t2_err_valid", err_valid, 1);
        chk("t2_err_code", err_code, 1);
        chk("t2_err_ch", err_ch, 1);
        chk("t2_sticky_code", sticky_code, 1);
        chk("t2_err_count", err_count, 1);
        cyc(1);
        chk("t2_pulse_end", err_valid, 0);

        // 3: payload change on ch2 then handshake
        vld[2] = 1'b1; pay[2] = 16'h0010;
        cyc(2);
        pay[2] = 16'h0011;
        cyc(1);
        chk("t3_err_code", err_code, 2);
        chk("t3_err_ch", err_ch, 2);
        chk("t3_sticky_ch", sticky_ch, 1);
        rdy[2] = 1'b1;
        cyc(1);
        chk("t3_fire2", fire_of(2), 1);
        chk("t3_err_valid", err_valid, 0);
        vld[2] = 1'b0; rdy[2] = 1'b0;
        cyc(1);

        // clear with nothing pending
        clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("clr_sticky", sticky_err, 0);
        chk("clr_count", err_count, 0);

        // 4: long stall on ch3, one timeout pulse
        vld[3] = 1'b1; pay[3] = 16'h0033;
        pulses = 0; pk = 0; pcode = 0;
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            if (err_valid === 1'b1) begin
                pulses++; pk = k; pcode = err_code;
            end
        end
        chk("t4_pulses", pulses, 1);
        chk("t4_pulse_cycle", pk, TO);
        chk("t4_code", pcode, 3);
        chk("t4_err_count", err_count, 1);
        chk("t4_sticky_ch", sticky_ch, 3);
        rdy[3] = 1'b1;
        cyc(1);
        vld[3] = 1'b0; rdy[3] = 1'b0;
        cyc(1);

        // 5: simultaneous drop on ch0 and change on ch3
        vld[0] = 1'b1; pay[0] = 16'h0001;
        vld[3] = 1'b1; pay[3] = 16'h0002;
        cyc(1);
        vld[0] = 1'b0; pay[3] = 16'h0003;
        cyc(1);
        chk("t5_err_ch", err_ch, 0);
        chk("t5_err_code", err_code, 1);
        chk("t5_err_count", err_count, 3);
        chk("t5_sticky_code", sticky_code, 3);
        rdy[3] = 1'b1;
        cyc(1);
        vld[3] = 1'b0; rdy[3] = 1'b0;
        cyc(1);

        // 6: clear with a pending detection, then enable=0 drop
        vld[1] = 1'b1;
        cyc(1);
        vld[1] = 1'b0; clear = 1'b1;
        cyc(1);
        clear = 1'b0;
        chk("t6_sticky", sticky_err, 0);
        chk("t6_count", err_count, 0);
        vld[1] = 1'b1;
        cyc(1);
        enable = 1'b0; vld[1] = 1'b0; vld[0] = 1'b1; rdy[0] = 1'b1;
        cyc(1);
        chk("t6_dis_err_valid", err_valid, 0);
        chk("t6_dis_fire0", fire_of(0), 1);
        enable = 1'b1; vld[0] = 1'b0; rdy[0] = 1'b0;
        cyc(2);
        chk("t6_en_err_valid", err_valid, 0);
        chk("t6_en_count", err_count, 0);

        // 7: saturation of fire and error counters
        vld[0] = 1'b1; rdy[0] = 1'b1;
        cyc(20);
        chk("t7_fire_sat", fire_of(0), SAT);
        vld[0] = 1'b0; rdy[0] = 1'b0;
        for (int r = 0; r < 8; r++) begin
            vld[1] = 1'b1; vld[2] = 1'b1;
            cyc(1);
            vld[1] = 1'b0; vld[2] = 1'b0;
            cyc(1);
        end
        chk("t7_count_sat", err_count, SAT);
        chk("t7_sticky_ch", sticky_ch, 1);

        // 8: reset in the middle of a stall
        vld[2] = 1'b1;
        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("t8_rst_count", err_count, 0);
        chk("t8_rst_fire", fire_cnt, 0);
        reset = 1'b0; vld[2] = 1'b0;
        cyc(2);
        chk("t8_no_pulse", err_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
